cntr_bs_sel: RTL

Pop-selection stage of the memory-controller bank scheduler. Each cycle it inspects the head entries of the bank's 4 read FIFOs and 3 write FIFOs, using their empty, mid and first_burst status. It chooses at most one FIFO to pop, as a one-hot vector that drives the bank datapath pop input. It implements read/write mode batching with bus turnaround, row-hit-first ordering against the tracked open row, round-robin fairness and starvation bounding.

---
 rtl/cntr_bs_sel.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cntr_bs_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cntr_bs_sel : bank scheduler pop selection (batching, row-hit, fairness)   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module cntr_bs_sel #(
    parameter int RD_FIFO_NUM = 4,
    parameter int WR_FIFO_NUM = 3,
    parameter int RA          = 16,
    parameter int CA          = 10,
    parameter int TURN        = 2,
    parameter int WR_BATCH    = 4,
    parameter int STARVE_MAX  = 8,
    parameter int FIFO_NUM    = RD_FIFO_NUM + WR_FIFO_NUM,
    parameter int BURST       = RA + CA - 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [FIFO_NUM-1:0]            empty,
    input  logic [FIFO_NUM-1:0]            mid,
    input  logic [FIFO_NUM-1:0][BURST-1:0] first_burst,
    input  logic                           ready,
    output logic [FIFO_NUM-1:0]            pop,
    output logic                           mode,
    output logic                           turn,
    output logic [RA-1:0]                  open_row,
    output logic                           open_row_valid
);

    localparam int IDX_W = $clog2(FIFO_NUM);
    localparam int TC_W  = (TURN > 1) ? $clog2(TURN) : 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam int WC_W  = $clog2(WR_BATCH + 1);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   pos_t;
    typedef logic [TC_W-1:0]  tc_t;
    typedef logic [SC_W-1:0]  sc_t;
    typedef logic [WC_W-1:0]  wc_t;

    localparam pos_t                RD_N    = pos_t'(RD_FIFO_NUM);
    localparam pos_t                WR_N    = pos_t'(WR_FIFO_NUM);
    localparam logic [FIFO_NUM-1:0] RD_MASK = FIFO_NUM'((1 << RD_FIFO_NUM) - 1);
    localparam logic [FIFO_NUM-1:0] WR_MASK = ~RD_MASK;
    localparam sc_t                 SC_MAX  = sc_t'(STARVE_MAX);
    localparam wc_t                 WC_MAX  = wc_t'(WR_BATCH);

    typedef enum logic [1:0] {
        ST_RD     = 2'd0,
        ST_TURN_W = 2'd1,
        ST_WR     = 2'd2,
        ST_TURN_R = 2'd3
    } state_e;

    state_e          state_q, state_d;
    tc_t             tcnt_q, tcnt_d;
    idx_t            rd_rr_q, rd_rr_d;
    idx_t            wr_rr_q, wr_rr_d;
    logic [RA-1:0]   row_q, row_d;
    logic            row_vld_q, row_vld_d;
    sc_t             starve_q, starve_d;
    wc_t             wcnt_q, wcnt_d;

    logic [RA-1:0]       w_head_row [FIFO_NUM];
    logic [FIFO_NUM-1:0] w_elig, w_hit, w_cand;
    logic                w_any_rd_ne, w_any_wr_ne, w_any_wr_mid, w_sw;
    logic                w_use_hit, w_found, w_do_pop;
    pos_t                w_base, w_span, w_ptr, w_pos, w_next;
    idx_t                w_win;

    for (genvar gi = 0; gi < FIFO_NUM; gi++) begin : g_hit
        assign w_head_row[gi] = RA'(first_burst[gi] >> (BURST - RA));
        assign w_hit[gi]      = w_elig[gi] & row_vld_q & (w_head_row[gi] == row_q);
    end

    assign w_any_rd_ne  = |(~empty & RD_MASK);
    assign w_any_wr_ne  = |(~empty & WR_MASK);
    assign w_any_wr_mid = |(mid & WR_MASK);
    assign w_elig       = (state_q == ST_RD) ? (~empty & RD_MASK) :
                          (state_q == ST_WR) ? (~empty & WR_MASK) : '0;
    assign w_use_hit    = (starve_q < SC_MAX) && (|w_hit);
    assign w_cand       = w_use_hit ? w_hit : w_elig;

    always_comb begin
        w_sw = 1'b0;
        case (state_q)
            ST_RD: w_sw = w_any_wr_mid | (~w_any_rd_ne & w_any_wr_ne);
            ST_WR: w_sw = (~w_any_wr_ne & w_any_rd_ne) |
                          ((wcnt_q >= WC_MAX) & ~w_any_wr_mid & w_any_rd_ne);
            default: w_sw = 1'b0;
        endcase
    end

    // Rotating scan inside the active mode's index range, starting at its rr pointer.
    always_comb begin
        w_base = '0;
        w_span = RD_N;
        w_ptr  = {1'b0, rd_rr_q};
        if (state_q == ST_WR) begin
            w_base = RD_N;
            w_span = WR_N;
            w_ptr  = {1'b0, wr_rr_q};
        end
        w_found = 1'b0;
        w_win   = '0;
        w_pos   = '0;
        for (int j = 0; j < FIFO_NUM; j++) begin
            w_pos = w_ptr + pos_t'(j);
            if (w_pos >= w_base + w_span) w_pos = w_pos - w_span;
            if (!w_found && (pos_t'(j) < w_span) && w_cand[w_pos[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_pos[IDX_W-1:0];
            end
        end
        w_next = {1'b0, w_win} + pos_t'(1);
        if (w_next >= w_base + w_span) w_next = w_base;
    end

    assign w_do_pop = ~rst & ~w_sw & ready & w_found;
    assign pop      = w_do_pop ? (FIFO_NUM'(1) << w_win) : '0;

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        rd_rr_d   = rd_rr_q;
        wr_rr_d   = wr_rr_q;
        row_d     = row_q;
        row_vld_d = row_vld_q;
        starve_d  = starve_q;
        wcnt_d    = wcnt_q;
        case (state_q)
            ST_RD: if (w_sw) begin
                state_d = ST_TURN_W;
                tcnt_d  = tc_t'(TURN - 1);
            end
            ST_TURN_W: if (tcnt_q == '0) begin
                state_d = ST_WR;
                wcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q - tc_t'(1);
            end
            ST_WR: if (w_sw) begin
                state_d = ST_TURN_R;
                tcnt_d  = tc_t'(TURN - 1);
            end
            ST_TURN_R: if (tcnt_q == '0) begin
                state_d = ST_RD;
            end else begin
                tcnt_d = tcnt_q - tc_t'(1);
            end
            default: state_d = ST_RD;
        endcase
        if (w_do_pop) begin
            if (state_q == ST_WR) begin
                wr_rr_d = w_next[IDX_W-1:0];
                if (wcnt_q != WC_MAX) wcnt_d = wcnt_q + wc_t'(1);
            end else begin
                rd_rr_d = w_next[IDX_W-1:0];
            end
            row_d     = w_head_row[w_win];
            row_vld_d = 1'b1;
            // Only a hit that jumped over a waiting miss counts toward starvation.
            if (w_hit[w_win]) begin
                if ((|(w_elig & ~w_hit)) && (starve_q != SC_MAX)) starve_d = starve_q + sc_t'(1);
            end else begin
                starve_d = '0;
            end
        end
        if (state_d != state_q) starve_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RD;
            tcnt_q    <= '0;
            rd_rr_q   <= '0;
            wr_rr_q   <= idx_t'(RD_FIFO_NUM);
            row_q     <= '0;
            row_vld_q <= 1'b0;
            starve_q  <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            rd_rr_q   <= rd_rr_d;
            wr_rr_q   <= wr_rr_d;
            row_q     <= row_d;
            row_vld_q <= row_vld_d;
            starve_q  <= starve_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign mode           = (state_q == ST_RD) || (state_q == ST_TURN_W);
    assign turn           = (state_q == ST_TURN_W) || (state_q == ST_TURN_R);
    assign open_row       = row_q;
    assign open_row_valid = row_vld_q;

endmodule
`default_nettype wire
